// File: rtl/sdr_wb_arb_pkg.sv
// sdr_wb_arb_pkg: shared state type and default parameters for the SDRAM Wishbone arbiter
package sdr_wb_arb_pkg;
    typedef enum logic {ARB, OWN} arb_state_e;
    localparam int NUM_M_DEF   = 4;
    localparam int AW_DEF      = 26;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/sdr_wb_arb_rr_pick.sv
// sdr_wb_arb_rr_pick: one-hot round-robin pick of the first requester after last_i
module sdr_wb_arb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         pick_o
);
    localparam int LW = $clog2(N);
    logic [LW:0]    sh;
    logic [2*N-1:0] rot_w, back_w;
    logic [N-1:0]   rot, iso;
    // rotate so the slot after last is bit 0, isolate the lowest request, rotate back
    always_comb begin
        sh     = {1'b0, last_i} + (LW+1)'(1);
        rot_w  = {req_i, req_i} >> sh;
        rot    = rot_w[N-1:0];
        iso    = rot & (~rot + N'(1));
        back_w = {iso, iso} << sh;
        pick_o = back_w[2*N-1:N];
    end
endmodule

// File: rtl/sdr_wb_arbiter.sv
// sdr_wb_arbiter: round-robin sharing of the sdrc Wishbone slave port with a stall watchdog
module sdr_wb_arbiter
    import sdr_wb_arb_pkg::*;
#(
    parameter int NUM_M   = NUM_M_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_M-1:0]       m_cyc_i,
    input  logic [NUM_M-1:0]       m_stb_i,
    input  logic [NUM_M-1:0]       m_we_i,
    input  logic [NUM_M*AW-1:0]    m_adr_i,
    input  logic [NUM_M*DW-1:0]    m_dat_i,
    input  logic [NUM_M*DW/8-1:0]  m_sel_i,
    output logic [DW-1:0]          m_dat_o,
    output logic [NUM_M-1:0]       m_ack_o,
    output logic [NUM_M-1:0]       m_err_o,
    output logic [NUM_M-1:0]       gnt_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [DW/8-1:0]        s_sel_o,
    input  logic [DW-1:0]          s_dat_i,
    input  logic                   s_ack_i
);
    localparam int LW = $clog2(NUM_M);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = DW / 8;

    arb_state_e       state_q;
    logic [NUM_M-1:0] gnt_q, blocked_q, blocked_d, req, pick;
    logic [LW-1:0]    idx_q, last_q, pick_idx;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             stall, expire;

    sdr_wb_arb_rr_pick #(.N(NUM_M)) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .pick_o (pick)
    );

    // binary index of the one-hot pick, kept alongside the grant for the muxes
    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_M; k++)
            if (pick[k]) pick_idx = LW'(k);
    end

    // owner muxes, ack/err steering, watchdog next value and blocked bookkeeping
    always_comb begin
        s_cyc_o   = (state_q == OWN) & m_cyc_i[idx_q];
        s_stb_o   = s_cyc_o & m_stb_i[idx_q];
        s_we_o    = m_we_i[idx_q];
        s_adr_o   = m_adr_i[idx_q*AW +: AW];
        s_dat_o   = m_dat_i[idx_q*DW +: DW];
        s_sel_o   = m_sel_i[idx_q*SW +: SW];
        m_dat_o   = s_dat_i;
        stall     = s_stb_o & ~s_ack_i;
        expire    = (TIMEOUT != 0) && stall && (32'(wdog_q) == 32'(TIMEOUT - 1));
        wdog_d    = stall ? ((&wdog_q) ? wdog_q : wdog_q + WW'(1)) : '0;
        m_ack_o   = (s_ack_i & s_stb_o & ~wb_rst_i) ? gnt_q : '0;
        m_err_o   = (expire & ~wb_rst_i) ? gnt_q : '0;
        blocked_d = (blocked_q & m_cyc_i) | (expire ? gnt_q : '0);
        req       = m_cyc_i & ~blocked_q;
        gnt_o     = gnt_q;
    end

    // arbitration FSM: grant in ARB, hold for the whole cyc in OWN, release on cyc fall or timeout
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ARB;
            gnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= LW'(NUM_M - 1);
            wdog_q    <= '0;
            blocked_q <= '0;
        end else begin
            blocked_q <= blocked_d;
            if (state_q == ARB) begin
                if (|req) begin
                    gnt_q   <= pick;
                    idx_q   <= pick_idx;
                    state_q <= OWN;
                end
            end else if (!m_cyc_i[idx_q] || expire) begin
                last_q  <= idx_q;
                gnt_q   <= '0;
                wdog_q  <= '0;
                state_q <= ARB;
            end else begin
                wdog_q <= wdog_d;
            end
        end
    end
endmodule
